alu_share_arbiter: RTL and testbench

Shares one combinational ALU between two requesters: requester 0 is execute-stage integer ops, requester 1 is address/branch-compare ops. Each requester has a valid/ready handshake. A round-robin grant steers the winner's opcode and operands into the ALU. The ALU result is captured in a single response register with a valid/ready handshake, and the block generates its own zero flag from the captured result.

---
 rtl/alu_share_arbiter.sv | 88 ++++++++
 tb/tb_alu_share_arbiter.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/alu_share_arbiter.sv
// Round-robin arbiter sharing one combinational ALU between two requesters,
// with a single registered response slot and a locally derived zero flag.
module alu_share_arbiter #(
  parameter int XLEN = 32,
  parameter int OPW  = 5
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            req0_valid,
  output logic            req0_ready,
  input  logic [OPW-1:0]  req0_op,
  input  logic [XLEN-1:0] req0_a,
  input  logic [XLEN-1:0] req0_b,
  input  logic            req1_valid,
  output logic            req1_ready,
  input  logic [OPW-1:0]  req1_op,
  input  logic [XLEN-1:0] req1_a,
  input  logic [XLEN-1:0] req1_b,
  output logic [OPW-1:0]  alu_op,
  output logic [XLEN-1:0] alu_a,
  output logic [XLEN-1:0] alu_b,
  input  logic [XLEN-1:0] alu_result,
  input  logic            flush,
  output logic            rsp_valid,
  input  logic            rsp_ready,
  output logic            rsp_id,
  output logic [XLEN-1:0] rsp_result,
  output logic            rsp_zero,
  output logic            rsp_err
);

  localparam logic [OPW-1:0] OP_MAX = OPW'(9);

  logic            last_grant;
  logic            gnt_valid;
  logic            gnt_id;
  logic            gnt_legal;
  logic [OPW-1:0]  gnt_op;
  logic [XLEN-1:0] gnt_a;
  logic [XLEN-1:0] gnt_b;
  logic            can_accept;
  logic            accept;
  logic [XLEN-1:0] cap_result;

  // Grant is suppressed during reset so readies and ALU inputs sit at idle.
  always_comb begin
    gnt_valid = rst_n && (req0_valid || req1_valid);
    if (req0_valid && req1_valid) gnt_id = ~last_grant;
    else                          gnt_id = !req0_valid;
    gnt_op    = gnt_id ? req1_op : req0_op;
    gnt_a     = gnt_id ? req1_a  : req0_a;
    gnt_b     = gnt_id ? req1_b  : req0_b;
    gnt_legal = (gnt_op <= OP_MAX);
  end

  assign can_accept = !rsp_valid || rsp_ready || flush;
  assign accept     = gnt_valid && can_accept;
  assign req0_ready = accept && !gnt_id;
  assign req1_ready = accept &&  gnt_id;

  // Illegal opcodes never reach the ALU; it sees a quiet ADD 0,0 instead.
  assign alu_op = (gnt_valid && gnt_legal) ? gnt_op : '0;
  assign alu_a  = (gnt_valid && gnt_legal) ? gnt_a  : '0;
  assign alu_b  = (gnt_valid && gnt_legal) ? gnt_b  : '0;

  assign cap_result = gnt_legal ? alu_result : '0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rsp_valid  <= 1'b0;
      rsp_id     <= 1'b0;
      rsp_result <= '0;
      rsp_zero   <= 1'b0;
      rsp_err    <= 1'b0;
      last_grant <= 1'b1;
    end else if (accept) begin
      rsp_valid  <= 1'b1;
      rsp_id     <= gnt_id;
      rsp_result <= cap_result;
      rsp_zero   <= (cap_result == '0);
      rsp_err    <= !gnt_legal;
      last_grant <= gnt_id;
    end else if (rsp_ready || flush) begin
      rsp_valid  <= 1'b0;
    end
  end

endmodule

// File: tb/tb_alu_share_arbiter.sv
// Bench for alu_share_arbiter: directed vector table, flush/reset sequences,
// then random traffic against a cycle-level behavioural model.
module tb_alu_share_arbiter;

  logic        clk;
  logic        rst_n;
  logic        req0_valid, req1_valid;
  logic        req0_ready, req1_ready;
  logic [4:0]  req0_op, req1_op;
  logic [31:0] req0_a, req0_b, req1_a, req1_b;
  logic [4:0]  alu_op;
  logic [31:0] alu_a, alu_b, alu_result;
  logic        flush;
  logic        rsp_valid, rsp_ready, rsp_id, rsp_zero, rsp_err;
  logic [31:0] rsp_result;

  int checks = 0;
  int failures = 0;

  alu_share_arbiter #(.XLEN(32), .OPW(5)) dut (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_op(req0_op),
    .req0_a(req0_a), .req0_b(req0_b),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_op(req1_op),
    .req1_a(req1_a), .req1_b(req1_b),
    .alu_op(alu_op), .alu_a(alu_a), .alu_b(alu_b), .alu_result(alu_result),
    .flush(flush),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
    .rsp_result(rsp_result), .rsp_zero(rsp_zero), .rsp_err(rsp_err)
  );

  function automatic logic [31:0] alu_f(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b);
    case (op)
      5'd0: return a + b;
      5'd1: return a - b;
      5'd2: return a << b[4:0];
      5'd3: return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      5'd4: return (a < b) ? 32'd1 : 32'd0;
      5'd5: return a ^ b;
      5'd6: return a >> b[4:0];
      5'd7: return 32'($signed(a) >>> b[4:0]);
      5'd8: return a | b;
      5'd9: return a & b;
      default: return 32'd0;
    endcase
  endfunction

  assign alu_result = alu_f(alu_op, alu_a, alu_b);

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  typedef struct {
    logic        v0; logic [4:0] op0; logic [31:0] a0; logic [31:0] b0;
    logic        v1; logic [4:0] op1; logic [31:0] a1; logic [31:0] b1;
    logic        rr; logic fl;
    logic        er0; logic er1;
    logic [4:0]  eop; logic [31:0] ea; logic [31:0] eb;
    logic        ev; logic eid; logic [31:0] eres; logic ez; logic ee;
  } vec_t;

  vec_t vecs[12];

  // model state
  logic        m_valid, m_id, m_z, m_e, m_last;
  logic [31:0] m_res;

  task automatic set_in(input logic v0, input logic [4:0] op0, input logic [31:0] a0, input logic [31:0] b0,
                        input logic v1, input logic [4:0] op1, input logic [31:0] a1, input logic [31:0] b1,
                        input logic rr, input logic fl);
    req0_valid = v0; req0_op = op0; req0_a = a0; req0_b = b0;
    req1_valid = v1; req1_op = op1; req1_a = a1; req1_b = b1;
    rsp_ready = rr; flush = fl;
  endtask

  task automatic chk_rsp(input string tag, input logic v, input logic id, input logic [31:0] res,
                         input logic z, input logic e);
    chk({tag, ".rsp_valid"}, 32'(rsp_valid), 32'(v));
    chk({tag, ".rsp_id"}, 32'(rsp_id), 32'(id));
    chk({tag, ".rsp_result"}, rsp_result, res);
    chk({tag, ".rsp_zero"}, 32'(rsp_zero), 32'(z));
    chk({tag, ".rsp_err"}, 32'(rsp_err), 32'(e));
  endtask

  initial begin
    int g;
    logic can, legal;
    logic [4:0] gop;
    logic [31:0] ga, gb;

    vecs[0]  = '{1'b1, 5'd1, 32'd9, 32'd9, 1'b1, 5'd5, 32'd3, 32'd3, 1'b1, 1'b0, 1'b1, 1'b0, 5'd1, 32'd9, 32'd9, 1'b1, 1'b0, 32'd0, 1'b1, 1'b0};
    vecs[1]  = '{1'b1, 5'd1, 32'd9, 32'd9, 1'b1, 5'd5, 32'd3, 32'd3, 1'b1, 1'b0, 1'b0, 1'b1, 5'd5, 32'd3, 32'd3, 1'b1, 1'b1, 32'd0, 1'b1, 1'b0};
    vecs[2]  = '{1'b1, 5'd1, 32'd9, 32'd9, 1'b1, 5'd5, 32'd3, 32'd3, 1'b1, 1'b0, 1'b1, 1'b0, 5'd1, 32'd9, 32'd9, 1'b1, 1'b0, 32'd0, 1'b1, 1'b0};
    vecs[3]  = '{1'b1, 5'd1, 32'd9, 32'd9, 1'b1, 5'd5, 32'd3, 32'd3, 1'b1, 1'b0, 1'b0, 1'b1, 5'd5, 32'd3, 32'd3, 1'b1, 1'b1, 32'd0, 1'b1, 1'b0};
    vecs[4]  = '{1'b1, 5'd0, 32'd5, 32'd7, 1'b0, 5'd0, 32'd0, 32'd0, 1'b1, 1'b0, 1'b1, 1'b0, 5'd0, 32'd5, 32'd7, 1'b1, 1'b0, 32'd12, 1'b0, 1'b0};
    vecs[5]  = '{1'b0, 5'd0, 32'd0, 32'd0, 1'b1, 5'd2, 32'd1, 32'd4, 1'b1, 1'b0, 1'b0, 1'b1, 5'd2, 32'd1, 32'd4, 1'b1, 1'b1, 32'd16, 1'b0, 1'b0};
    vecs[6]  = '{1'b0, 5'd0, 32'd0, 32'd0, 1'b1, 5'd0, 32'd2, 32'd3, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 32'd2, 32'd3, 1'b1, 1'b1, 32'd16, 1'b0, 1'b0};
    vecs[7]  = vecs[6];
    vecs[8]  = vecs[6];
    vecs[9]  = '{1'b0, 5'd0, 32'd0, 32'd0, 1'b1, 5'd0, 32'd2, 32'd3, 1'b1, 1'b0, 1'b0, 1'b1, 5'd0, 32'd2, 32'd3, 1'b1, 1'b1, 32'd5, 1'b0, 1'b0};
    vecs[10] = '{1'b1, 5'd12, 32'hFFFF_FFFF, 32'd1, 1'b0, 5'd0, 32'd0, 32'd0, 1'b1, 1'b0, 1'b1, 1'b0, 5'd0, 32'd0, 32'd0, 1'b1, 1'b0, 32'd0, 1'b1, 1'b1};
    vecs[11] = '{1'b0, 5'd0, 32'd0, 32'd0, 1'b0, 5'd0, 32'd0, 32'd0, 1'b1, 1'b0, 1'b0, 1'b0, 5'd0, 32'd0, 32'd0, 1'b0, 1'b0, 32'd0, 1'b1, 1'b1};

    // reset with both requesters valid
    rst_n = 1'b0;
    set_in(1'b1, 5'd3, 32'd11, 32'd22, 1'b1, 5'd8, 32'd33, 32'd44, 1'b1, 1'b0);
    #12;
    chk_rsp("reset", 1'b0, 1'b0, 32'd0, 1'b0, 1'b0);
    chk("reset.req0_ready", 32'(req0_ready), 32'd0);
    chk("reset.req1_ready", 32'(req1_ready), 32'd0);
    chk("reset.alu_op", 32'(alu_op), 32'd0);
    chk("reset.alu_a", alu_a, 32'd0);
    chk("reset.alu_b", alu_b, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("release.req0_ready", 32'(req0_ready), 32'd1);
    chk("release.req1_ready", 32'(req1_ready), 32'd0);
    req0_valid = 1'b0; req1_valid = 1'b0;
    @(posedge clk); #1;

    for (int i = 0; i < 12; i++) begin
      set_in(vecs[i].v0, vecs[i].op0, vecs[i].a0, vecs[i].b0,
             vecs[i].v1, vecs[i].op1, vecs[i].a1, vecs[i].b1, vecs[i].rr, vecs[i].fl);
      @(negedge clk);
      chk($sformatf("vec%0d.req0_ready", i), 32'(req0_ready), 32'(vecs[i].er0));
      chk($sformatf("vec%0d.req1_ready", i), 32'(req1_ready), 32'(vecs[i].er1));
      chk($sformatf("vec%0d.alu_op", i), 32'(alu_op), 32'(vecs[i].eop));
      chk($sformatf("vec%0d.alu_a", i), alu_a, vecs[i].ea);
      chk($sformatf("vec%0d.alu_b", i), alu_b, vecs[i].eb);
      @(posedge clk); #1;
      chk_rsp($sformatf("vec%0d", i), vecs[i].ev, vecs[i].eid, vecs[i].eres, vecs[i].ez, vecs[i].ee);
    end

    // flush of a held response with no new request
    set_in(1'b1, 5'd0, 32'd1, 32'd1, 1'b0, 5'd0, 32'd0, 32'd0, 1'b0, 1'b0);
    @(posedge clk); #1;
    chk_rsp("flushA", 1'b1, 1'b0, 32'd2, 1'b0, 1'b0);
    set_in(1'b0, 5'd0, 32'd0, 32'd0, 1'b0, 5'd0, 32'd0, 32'd0, 1'b0, 1'b1);
    @(posedge clk); #1;
    chk_rsp("flushB", 1'b0, 1'b0, 32'd2, 1'b0, 1'b0);
    // flush with a same-cycle accept replaces the held response
    set_in(1'b0, 5'd0, 32'd0, 32'd0, 1'b1, 5'd0, 32'd4, 32'd4, 1'b0, 1'b0);
    @(posedge clk); #1;
    chk_rsp("flushC", 1'b1, 1'b1, 32'd8, 1'b0, 1'b0);
    set_in(1'b1, 5'd0, 32'd0, 32'd0, 1'b0, 5'd0, 32'd0, 32'd0, 1'b0, 1'b1);
    @(negedge clk);
    chk("flushD.req0_ready", 32'(req0_ready), 32'd1);
    @(posedge clk); #1;
    chk_rsp("flushD", 1'b1, 1'b0, 32'd0, 1'b1, 1'b0);

    // asynchronous reset mid-cycle with a response held
    set_in(1'b1, 5'd0, 32'd3, 32'd3, 1'b1, 5'd0, 32'd5, 32'd5, 1'b0, 1'b0);
    #2 rst_n = 1'b0;
    #1;
    chk_rsp("midrst", 1'b0, 1'b0, 32'd0, 1'b0, 1'b0);
    chk("midrst.req0_ready", 32'(req0_ready), 32'd0);
    chk("midrst.req1_ready", 32'(req1_ready), 32'd0);
    chk("midrst.alu_a", alu_a, 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("midrst_release.req0_ready", 32'(req0_ready), 32'd1);
    chk("midrst_release.req1_ready", 32'(req1_ready), 32'd0);
    req0_valid = 1'b0; req1_valid = 1'b0;
    @(posedge clk); #1;

    // random traffic against the behavioural model
    m_valid = 1'b0; m_id = 1'b0; m_res = 32'd0; m_z = 1'b0; m_e = 1'b0; m_last = 1'b1;
    for (int c = 0; c < 500; c++) begin
      set_in(($urandom_range(0, 3) != 0), 5'($urandom_range(0, 13)),
             ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 2)) : $urandom,
             ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 2)) : $urandom,
             ($urandom_range(0, 3) != 0), 5'($urandom_range(0, 13)),
             ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 2)) : $urandom,
             ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 2)) : $urandom,
             ($urandom_range(0, 2) != 0), ($urandom_range(0, 7) == 0));
      @(negedge clk);
      if (req0_valid && req1_valid) g = m_last ? 0 : 1;
      else if (req0_valid)          g = 0;
      else if (req1_valid)          g = 1;
      else                          g = -1;
      can   = !m_valid || rsp_ready || flush;
      gop   = (g == 1) ? req1_op : req0_op;
      ga    = (g == 1) ? req1_a  : req0_a;
      gb    = (g == 1) ? req1_b  : req0_b;
      legal = (gop < 5'd10);
      chk("rnd.req0_ready", 32'(req0_ready), 32'(can && g == 0));
      chk("rnd.req1_ready", 32'(req1_ready), 32'(can && g == 1));
      chk("rnd.alu_op", 32'(alu_op), (g >= 0 && legal) ? 32'(gop) : 32'd0);
      chk("rnd.alu_a", alu_a, (g >= 0 && legal) ? ga : 32'd0);
      chk("rnd.alu_b", alu_b, (g >= 0 && legal) ? gb : 32'd0);
      if (g >= 0 && can) begin
        m_valid = 1'b1;
        m_id    = (g == 1);
        m_res   = legal ? alu_f(gop, ga, gb) : 32'd0;
        m_e     = !legal;
        m_z     = (m_res == 32'd0);
        m_last  = (g == 1);
      end else if (rsp_ready || flush) begin
        m_valid = 1'b0;
      end
      @(posedge clk); #1;
      chk_rsp("rnd", m_valid, m_id, m_res, m_z, m_e);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
